tdm_rx_framed: RTL and testbench

Parametrised TDM serial-audio receiver with frame-sync tracking. It deserialises `sd_in` into per-slot PCM words, tags each word with its slot number and an end-of-frame marker, and delivers words over a valid/ready handshake. Per-slot enables, selectable frame-sync delay, loss-of-sync detection and saturating error counters are included. It sits between the TDM input pins (bclk domain) and the downstream sample FIFO or CDC stage.

---
 rtl/tdm_rx_framed.sv | 210 +++++++++++++++++++++
 tb/tb_tdm_rx_framed.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_rx_framed.sv
`default_nettype none
// ============================================================================
// Module      : tdm_rx_framed
// Description : TDM serial-audio receiver with frame-sync tracking. It
//               deserialises sd_in into per-slot PCM words and hands them out
//               over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_rx_framed #(
    parameter int WORD_LEN     = 32,
    parameter int PCM_WIDTH    = 24,
    parameter int TDM_CHANNELS = 8,
    parameter int FS_DELAY     = 1,
    parameter int MISS_LIMIT   = 2,
    parameter int CH_W         = (TDM_CHANNELS > 1) ? $clog2(TDM_CHANNELS) : 1
) (
    input  logic                    bclk,
    input  logic                    rst,
    input  logic                    lrclk,
    input  logic                    sd_in,
    input  logic [TDM_CHANNELS-1:0] ch_en,
    input  logic                    cnt_clr,
    input  logic                    pcm_ready,
    output logic [PCM_WIDTH-1:0]    pcm_data,
    output logic [CH_W-1:0]         pcm_ch,
    output logic                    pcm_last,
    output logic                    pcm_valid,
    output logic                    locked,
    output logic [7:0]              sync_err_cnt,
    output logic [7:0]              ovf_cnt
);
    localparam int c_bit_w  = $clog2(WORD_LEN);
    localparam int c_miss_w = $clog2(MISS_LIMIT + 1);
    localparam logic [c_bit_w-1:0]  c_last_bit   = c_bit_w'(WORD_LEN - 1);
    localparam logic [CH_W-1:0]     c_last_slot  = CH_W'(TDM_CHANNELS - 1);
    localparam logic [c_miss_w-1:0] c_miss_limit = c_miss_w'(MISS_LIMIT);
    localparam logic [0:0] c_st_hunt = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic                 r_lrclk_q;
    logic                 w_fsync;
    logic                 w_fs_pos;
    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [CH_W-1:0]      r_slot_cnt;
    logic [c_miss_w-1:0]  r_miss_cnt;
    logic [c_miss_w-1:0]  w_miss_nxt;
    logic [PCM_WIDTH-1:0] r_shift;
    logic [PCM_WIDTH-1:0] w_shift_nxt;
    logic [PCM_WIDTH-1:0] w_word;
    logic                 w_take;
    logic                 w_at_start;
    logic                 w_restart;
    logic                 w_capture;
    logic                 w_sync_err;
    logic                 w_miss_inc;
    logic                 w_miss_clr;
    logic                 w_word_done;
    logic                 w_slot_en;
    logic                 w_load;
    logic                 w_drop;
    logic [CH_W-1:0]      w_top_slot;
    logic [PCM_WIDTH-1:0] r_pcm_data;
    logic [CH_W-1:0]      r_pcm_ch;
    logic                 r_pcm_last;
    logic                 r_pcm_valid;
    logic [7:0]           r_sync_err_cnt;
    logic [7:0]           r_ovf_cnt;

    assign w_fsync = lrclk & ~r_lrclk_q;

    generate
        if (FS_DELAY == 0) begin : g_fs_direct
            assign w_fs_pos = w_fsync;
        end else begin : g_fs_delayed
            logic [FS_DELAY-1:0] r_fs_dly;
            always_ff @(posedge bclk) begin
                if (rst) r_fs_dly <= '0;
                else     r_fs_dly <= FS_DELAY'({r_fs_dly, w_fsync});
            end
            assign w_fs_pos = r_fs_dly[FS_DELAY-1];
        end
    endgenerate

    assign w_at_start  = (r_bit_cnt == '0) && (r_slot_cnt == '0);
    assign w_miss_nxt  = r_miss_cnt + c_miss_w'(1);
    // Only the leading PCM_WIDTH bits of a slot are kept; the rest are don't-care.
    assign w_take      = (32'(r_bit_cnt) < 32'(PCM_WIDTH));
    assign w_shift_nxt = PCM_WIDTH'({r_shift, sd_in});
    assign w_word      = (PCM_WIDTH == WORD_LEN) ? w_shift_nxt : r_shift;

    always_ff @(posedge bclk) begin
        if (rst) r_state <= c_st_hunt;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_capture   = 1'b0;
        w_sync_err  = 1'b0;
        w_miss_inc  = 1'b0;
        w_miss_clr  = 1'b0;
        case (r_state)
            c_st_hunt: begin
                if (w_fs_pos) begin
                    w_state_nxt = c_st_run;
                    w_restart   = 1'b1;
                end
            end
            default: begin
                if (w_fs_pos && !w_at_start) begin
                    w_restart  = 1'b1;
                    w_sync_err = 1'b1;
                end else if (w_fs_pos) begin
                    w_capture  = 1'b1;
                    w_miss_clr = 1'b1;
                end else if (w_at_start) begin
                    // Flywheel through a missing sync until the limit is hit.
                    if (w_miss_nxt == c_miss_limit) begin
                        w_state_nxt = c_st_hunt;
                        w_miss_clr  = 1'b1;
                    end else begin
                        w_capture  = 1'b1;
                        w_miss_inc = 1'b1;
                    end
                end else begin
                    w_capture = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_top_slot = '0;
        for (int k = 0; k < TDM_CHANNELS; k++) begin
            if (ch_en[k]) w_top_slot = CH_W'(k);
        end
    end

    assign w_word_done = w_capture && (r_bit_cnt == c_last_bit);
    assign w_slot_en   = ch_en[r_slot_cnt];
    assign w_load      = w_word_done && w_slot_en && (!r_pcm_valid || pcm_ready);
    assign w_drop      = w_word_done && w_slot_en && r_pcm_valid && !pcm_ready;

    always_ff @(posedge bclk) begin
        if (rst) begin
            r_lrclk_q  <= 1'b0;
            r_bit_cnt  <= '0;
            r_slot_cnt <= '0;
            r_miss_cnt <= '0;
            r_shift    <= '0;
        end else begin
            r_lrclk_q <= lrclk;
            if (w_restart) begin
                r_shift    <= w_shift_nxt;
                r_bit_cnt  <= c_bit_w'(1);
                r_slot_cnt <= '0;
            end else if (w_capture) begin
                if (w_take) r_shift <= w_shift_nxt;
                if (r_bit_cnt == c_last_bit) begin
                    r_bit_cnt  <= '0;
                    r_slot_cnt <= (r_slot_cnt == c_last_slot) ? '0 : r_slot_cnt + CH_W'(1);
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                end
            end
            if (w_miss_clr || w_restart) r_miss_cnt <= '0;
            else if (w_miss_inc)         r_miss_cnt <= w_miss_nxt;
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            r_pcm_data     <= '0;
            r_pcm_ch       <= '0;
            r_pcm_last     <= 1'b0;
            r_pcm_valid    <= 1'b0;
            r_sync_err_cnt <= '0;
            r_ovf_cnt      <= '0;
        end else begin
            if (w_load) begin
                r_pcm_data  <= w_word;
                r_pcm_ch    <= r_slot_cnt;
                r_pcm_last  <= (r_slot_cnt == w_top_slot);
                r_pcm_valid <= 1'b1;
            end else if (pcm_ready) begin
                r_pcm_valid <= 1'b0;
            end
            if (cnt_clr) begin
                r_sync_err_cnt <= '0;
                r_ovf_cnt      <= '0;
            end else begin
                if (w_sync_err && (r_sync_err_cnt != 8'hFF)) r_sync_err_cnt <= r_sync_err_cnt + 8'd1;
                if (w_drop && (r_ovf_cnt != 8'hFF))          r_ovf_cnt      <= r_ovf_cnt + 8'd1;
            end
        end
    end

    assign pcm_data     = r_pcm_data;
    assign pcm_ch       = r_pcm_ch;
    assign pcm_last     = r_pcm_last;
    assign pcm_valid    = r_pcm_valid;
    assign locked       = (r_state == c_st_run);
    assign sync_err_cnt = r_sync_err_cnt;
    assign ovf_cnt      = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tdm_rx_framed.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_rx_framed
// Description : Directed and randomised bench for tdm_rx_framed with a
//               frame-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_rx_framed;
    localparam int WL  = 32;
    localparam int PW  = 24;
    localparam int NCH = 8;
    localparam int FSD = 1;
    localparam int ML  = 2;
    localparam int CHW = 3;
    localparam int FL  = WL * NCH;

    logic           bclk = 1'b0;
    logic           rst;
    logic           lrclk;
    logic           sd_in;
    logic [NCH-1:0] ch_en;
    logic           cnt_clr;
    logic           pcm_ready;
    logic [PW-1:0]  pcm_data;
    logic [CHW-1:0] pcm_ch;
    logic           pcm_last;
    logic           pcm_valid;
    logic           locked;
    logic [7:0]     sync_err_cnt;
    logic [7:0]     ovf_cnt;

    tdm_rx_framed #(
        .WORD_LEN(WL), .PCM_WIDTH(PW), .TDM_CHANNELS(NCH),
        .FS_DELAY(FSD), .MISS_LIMIT(ML)
    ) dut (
        .bclk(bclk), .rst(rst), .lrclk(lrclk), .sd_in(sd_in), .ch_en(ch_en),
        .cnt_clr(cnt_clr), .pcm_ready(pcm_ready), .pcm_data(pcm_data),
        .pcm_ch(pcm_ch), .pcm_last(pcm_last), .pcm_valid(pcm_valid),
        .locked(locked), .sync_err_cnt(sync_err_cnt), .ovf_cnt(ovf_cnt)
    );

    always #5 bclk = ~bclk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: receiver position is a single index into the frame.
    bit            m_locked = 0;
    int            m_pos    = 0;
    int            m_miss   = 0;
    logic [63:0]   m_word   = '0;
    bit            m_prev_lr = 0;
    bit            m_fs_d   = 0;
    logic [PW-1:0] m_data   = '0;
    int            m_ch     = 0;
    bit            m_last   = 0;
    bit            m_valid  = 0;
    int            m_sync   = 0;
    int            m_ovf    = 0;

    logic [PW-1:0] q_data[$];
    int            q_ch[$];
    bit            q_last[$];
    bit            v_prev = 0;

    logic [31:0]   tx_words[NCH];
    bit            g_sync_cur = 0;
    int            g_ready_mode = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit fsync, fspos, done, lose, serr, drop;
        int slot, top;
        if (rst) begin
            m_locked = 0; m_pos = 0; m_miss = 0; m_word = '0;
            m_prev_lr = 0; m_fs_d = 0; m_data = '0; m_ch = 0;
            m_last = 0; m_valid = 0; m_sync = 0; m_ovf = 0;
        end else begin
            fsync = lrclk && !m_prev_lr;
            fspos = (FSD == 0) ? fsync : m_fs_d;
            m_fs_d = fsync;
            m_prev_lr = lrclk;
            done = 0; lose = 0; serr = 0; drop = 0;
            slot = m_pos / WL;
            if (!m_locked) begin
                if (fspos) begin
                    m_locked = 1; m_word = {63'd0, sd_in}; m_pos = 1; m_miss = 0;
                end
            end else if (fspos && m_pos != 0) begin
                serr = 1; m_word = {63'd0, sd_in}; m_pos = 1; m_miss = 0;
            end else begin
                if (fspos) m_miss = 0;
                else if (m_pos == 0) begin
                    m_miss++;
                    if (m_miss == ML) begin
                        lose = 1; m_locked = 0; m_miss = 0;
                    end
                end
                if (!lose) begin
                    m_word = {m_word[62:0], sd_in};
                    done = (m_pos % WL == WL - 1);
                    m_pos = (m_pos + 1) % FL;
                end
            end
            top = 0;
            for (int k = 0; k < NCH; k++) if (ch_en[k]) top = k;
            if (done && ch_en[slot]) begin
                if (!m_valid || pcm_ready) begin
                    m_valid = 1; m_data = m_word[WL-1 -: PW]; m_ch = slot; m_last = (slot == top);
                end else drop = 1;
            end else if (pcm_ready) m_valid = 0;
            if (cnt_clr) begin
                m_sync = 0; m_ovf = 0;
            end else begin
                if (serr && m_sync < 255) m_sync++;
                if (drop && m_ovf < 255) m_ovf++;
            end
        end
    endtask

    task automatic step();
        bit rdy_used;
        model_update();
        rdy_used = pcm_ready;
        @(posedge bclk);
        #1;
        check("pcm_valid", pcm_valid, m_valid);
        check("locked", locked, m_locked);
        check("sync_err_cnt", sync_err_cnt, m_sync);
        check("ovf_cnt", ovf_cnt, m_ovf);
        check("pcm_data", pcm_data, m_data);
        check("pcm_ch", pcm_ch, m_ch);
        check("pcm_last", pcm_last, m_last);
        if (pcm_valid && (!v_prev || rdy_used)) begin
            q_data.push_back(pcm_data); q_ch.push_back(int'(pcm_ch)); q_last.push_back(pcm_last);
        end
        v_prev = pcm_valid;
    endtask

    task automatic qclear();
        q_data.delete(); q_ch.delete(); q_last.delete();
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < NCH; k++) tx_words[k] = 32'hA000_0000 + 32'(k) * 32'h0011_1100;
    endtask

    task automatic fill_random();
        for (int k = 0; k < NCH; k++) tx_words[k] = $urandom;
    endtask

    // lrclk is high over the first slot when this frame is synced, and on the
    // last transmitted bit when the following frame should be synced.
    task automatic send_frame(input bit sync_next, input int nbits);
        logic [31:0] w;
        for (int p = 0; p < nbits; p++) begin
            lrclk = (p < WL - 1) ? g_sync_cur : 1'b0;
            if (p == nbits - 1 && sync_next) lrclk = 1'b1;
            w = tx_words[p / WL];
            sd_in = w[WL - 1 - (p % WL)];
            if (g_ready_mode == 1) pcm_ready = 1'($urandom_range(0, 1));
            else if (g_ready_mode == 2) pcm_ready = (p == 0);
            step();
        end
        g_sync_cur = sync_next;
    endtask

    task automatic idle(input int n, input bit last_high);
        for (int p = 0; p < n; p++) begin
            lrclk = (p == n - 1) ? last_high : 1'b0;
            sd_in = 1'($urandom_range(0, 1));
            step();
        end
        g_sync_cur = last_high;
    endtask

    task automatic check_pattern_frame(input string tag);
        logic [31:0] w;
        check({tag, "_count"}, q_data.size(), NCH);
        for (int k = 0; k < q_data.size() && k < NCH; k++) begin
            w = 32'hA000_0000 + 32'(k) * 32'h0011_1100;
            check({tag, "_data"}, q_data[k], w[31:8]);
            check({tag, "_ch"}, q_ch[k], k);
            check({tag, "_last"}, q_last[k], (k == NCH - 1));
        end
    endtask

    initial begin
        rst = 1'b1; lrclk = 1'b0; sd_in = 1'b0; ch_en = '1;
        cnt_clr = 1'b0; pcm_ready = 1'b1;
        repeat (3) step();
        check("rst_locked", locked, 0);
        check("rst_valid", pcm_valid, 0);
        check("rst_data", pcm_data, 0);
        rst = 1'b0;

        // Basic capture
        idle(4, 1'b1);
        check("pre_lock", locked, 0);
        fill_pattern(); qclear();
        send_frame(1'b1, FL);
        check_pattern_frame("basic");
        check("basic_locked", locked, 1);

        // Slot enables
        ch_en = 8'b0000_0101;
        fill_random(); qclear();
        send_frame(1'b1, FL);
        check("en_count", q_data.size(), 2);
        if (q_data.size() == 2) begin
            check("en_ch0", q_ch[0], 0);
            check("en_ch1", q_ch[1], 2);
            check("en_last0", q_last[0], 0);
            check("en_last1", q_last[1], 1);
            check("en_data0", q_data[0], tx_words[0][31:8]);
            check("en_data1", q_data[1], tx_words[2][31:8]);
        end
        check("en_ovf", ovf_cnt, 0);
        ch_en = '1;

        // Early sync inside slot 4
        fill_pattern(); send_frame(1'b1, FL);
        fill_random(); qclear();
        send_frame(1'b1, 4 * WL + 11);
        check("early_partial_count", q_data.size(), 4);
        fill_pattern(); qclear();
        send_frame(1'b1, FL);
        check("early_sync_err", sync_err_cnt, 1);
        check("early_locked", locked, 1);
        check_pattern_frame("early_next");

        // Missing syncs
        fill_random(); send_frame(1'b0, FL);
        fill_random(); qclear();
        send_frame(1'b0, FL);
        check("miss1_count", q_data.size(), NCH);
        check("miss1_locked", locked, 1);
        fill_random(); qclear();
        send_frame(1'b1, FL);
        check("miss2_locked", locked, 0);
        check("miss2_count", q_data.size(), 0);
        fill_pattern(); qclear();
        send_frame(1'b1, FL);
        check_pattern_frame("relock");
        check("relock_sync_err", sync_err_cnt, 1);
        check("relock_locked", locked, 1);

        // Backpressure
        g_ready_mode = 2;
        fill_pattern();
        send_frame(1'b1, FL);
        check("bp_ovf", ovf_cnt, 7);
        check("bp_valid", pcm_valid, 1);
        check("bp_data", pcm_data, tx_words[0][31:8]);
        check("bp_ch", pcm_ch, 0);
        cnt_clr = 1'b1;
        fill_random();
        send_frame(1'b1, FL);
        check("clr_ovf", ovf_cnt, 0);
        check("clr_sync_err", sync_err_cnt, 0);
        cnt_clr = 1'b0;
        g_ready_mode = 0; pcm_ready = 1'b1;

        // Randomised frames, truncations, dropped syncs and backpressure
        g_ready_mode = 1;
        for (int f = 0; f < 10; f++) begin
            ch_en = NCH'($urandom);
            fill_random();
            send_frame(($urandom_range(0, 4) != 0),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(WL, FL - 1)) : FL);
        end
        g_ready_mode = 0; pcm_ready = 1'b1; ch_en = '1;
        fill_random(); send_frame(1'b1, FL);

        // Mid-frame reset at slot 3 bit 10
        fill_pattern();
        send_frame(1'b0, 3 * WL + 10);
        rst = 1'b1; lrclk = 1'b0;
        step();
        rst = 1'b0;
        check("mrst_valid", pcm_valid, 0);
        check("mrst_locked", locked, 0);
        check("mrst_data", pcm_data, 0);
        check("mrst_ch", pcm_ch, 0);
        check("mrst_last", pcm_last, 0);
        check("mrst_sync_err", sync_err_cnt, 0);
        check("mrst_ovf", ovf_cnt, 0);
        qclear();
        idle(20, 1'b1);
        check("mrst_idle_count", q_data.size(), 0);
        fill_pattern(); qclear();
        send_frame(1'b1, FL);
        check_pattern_frame("mrst_recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
